// File: rtl/cache_line_fill_pkg.sv
// Shared types and constants for the miss-side line-fill controller.
package cache_line_fill_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    FILL   = 2'd2,
    COMMIT = 2'd3
  } fill_state_e;

  localparam int unsigned RETRY_W = 8;

  // Width of a field that must exist even when its logical width is zero.
  function automatic int unsigned min_width(input int unsigned w);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/cache_line_fill.sv
// Line-fill controller: requests a line from the read channel, gathers the
// returned beats into a line buffer and commits the full line in one cycle.
module cache_line_fill
  import cache_line_fill_pkg::*;
#(
  parameter int unsigned FE_ADDR_W  = 32,
  parameter int unsigned FE_DATA_W  = 32,
  parameter int unsigned BE_DATA_W  = 32,
  parameter int unsigned WORD_OFF_W = 3,
  localparam int unsigned BE_BYTE_W  = $clog2(BE_DATA_W / 8),
  localparam int unsigned LINE2MEM_W = WORD_OFF_W - $clog2(BE_DATA_W / FE_DATA_W),
  localparam int unsigned LINE_W     = FE_DATA_W * (1 << WORD_OFF_W),
  localparam int unsigned LA_W       = FE_ADDR_W - BE_BYTE_W - LINE2MEM_W,
  localparam int unsigned RA_W       = min_width(LINE2MEM_W)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               miss_valid,
  input  logic [LA_W-1:0]    miss_addr,
  output logic               miss_ready,
  output logic               replace_valid,
  output logic [LA_W-1:0]    replace_addr,
  input  logic               replace,
  input  logic               read_valid,
  input  logic [RA_W-1:0]    read_addr,
  input  logic [BE_DATA_W-1:0] read_rdata,
  output logic               line_we,
  output logic [LA_W-1:0]    line_addr,
  output logic [LINE_W-1:0]  line_wdata,
  output logic               fill_busy,
  output logic [RETRY_W-1:0] fill_retries
);

  localparam int unsigned BEATS = 1 << LINE2MEM_W;
  localparam int unsigned CNT_W = LINE2MEM_W + 1;

  fill_state_e       state_q;
  fill_state_e       state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [RA_W-1:0]   slot;
  logic              accept;
  logic              beat;
  logic              rewrap;

  assign accept = (state_q == IDLE) && miss_valid;
  assign beat   = (state_q == FILL) && read_valid;
  // A beat arriving on a full counter means the channel restarted the burst.
  assign rewrap = (cnt_q == CNT_W'(BEATS));
  assign slot   = (LINE2MEM_W == 0) ? '0 : read_addr;

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (miss_valid) state_d = REQ;
      REQ:     if (replace)    state_d = FILL;
      FILL:    if (!replace)   state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register and registered state-decoded outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      miss_ready    <= 1'b1;
      replace_valid <= 1'b0;
      line_we       <= 1'b0;
      fill_busy     <= 1'b0;
    end else begin
      state_q       <= state_d;
      miss_ready    <= (state_d == IDLE);
      replace_valid <= (state_d == REQ);
      line_we       <= (state_d == COMMIT);
      fill_busy     <= (state_d != IDLE);
    end
  end

  // Miss address latch, beat counter and re-burst counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line_addr    <= '0;
      replace_addr <= '0;
      cnt_q        <= '0;
      fill_retries <= '0;
    end else if (accept) begin
      line_addr    <= miss_addr;
      replace_addr <= miss_addr;
      cnt_q        <= '0;
      fill_retries <= '0;
    end else if (beat) begin
      if (rewrap) begin
        cnt_q <= CNT_W'(1);
        if (fill_retries != '1) fill_retries <= fill_retries + RETRY_W'(1);
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  for (genvar k = 0; k < BEATS; k++) begin : g_slot
    logic [BE_DATA_W-1:0] slot_q;

    // Capture the beat addressed to this slot; later bursts overwrite it.
    always_ff @(posedge clk or posedge reset) begin
      if (reset)                             slot_q <= '0;
      else if (beat && (slot == RA_W'(k)))   slot_q <= read_rdata;
    end

    assign line_wdata[k*BE_DATA_W +: BE_DATA_W] = slot_q;
  end

endmodule

// File: tb/tb_cache_line_fill.sv
// Scoreboard bench for cache_line_fill with a behavioural read-channel model.
module tb_cache_line_fill;

  localparam int unsigned LA_W   = 27;
  localparam int unsigned DW     = 32;
  localparam int unsigned BEATS  = 8;
  localparam int unsigned LINE_W = 256;

  typedef struct {
    logic [LA_W-1:0]   addr;
    logic [LINE_W-1:0] line;
    logic [7:0]        retries;
  } exp_t;

  typedef struct {
    logic [LA_W-1:0]   addr;
    int                bursts;
    int                ar_delay;
    int                max_stall;
    int                abort_beat;
    logic [LINE_W-1:0] line;
  } plan_t;

  logic clk = 1'b0;
  logic reset;
  logic miss_valid, miss_ready, replace_valid, replace, read_valid;
  logic line_we, fill_busy;
  logic [LA_W-1:0] miss_addr, replace_addr, line_addr;
  logic [2:0] read_addr;
  logic [DW-1:0] read_rdata;
  logic [LINE_W-1:0] line_wdata;
  logic [7:0] fill_retries;

  logic reset2, miss_valid2, miss_ready2, replace_valid2, replace2, read_valid2;
  logic line_we2, fill_busy2;
  logic [LA_W-1:0] miss_addr2, replace_addr2, line_addr2;
  logic [0:0] read_addr2;
  logic [255:0] read_rdata2;
  logic [LINE_W-1:0] line_wdata2;
  logic [7:0] fill_retries2;

  int n_checks = 0;
  int n_pass = 0;
  int unsigned cyc = 0;
  int unsigned last_beat_cyc = 0;
  int unsigned last_commit_cyc = 0;
  int unsigned last2 = 0;
  int triggers = 0;
  int issued = 0;
  bit rst_done = 0;
  bit abort_done = 0;
  bit dut2_done = 0;

  plan_t plan_q[$];
  exp_t  exp_q[$];
  exp_t  exp2_q[$];
  exp_t  em, em2;

  cache_line_fill dut (
    .clk(clk), .reset(reset),
    .miss_valid(miss_valid), .miss_addr(miss_addr), .miss_ready(miss_ready),
    .replace_valid(replace_valid), .replace_addr(replace_addr), .replace(replace),
    .read_valid(read_valid), .read_addr(read_addr), .read_rdata(read_rdata),
    .line_we(line_we), .line_addr(line_addr), .line_wdata(line_wdata),
    .fill_busy(fill_busy), .fill_retries(fill_retries)
  );

  cache_line_fill #(.BE_DATA_W(256)) dut2 (
    .clk(clk), .reset(reset2),
    .miss_valid(miss_valid2), .miss_addr(miss_addr2), .miss_ready(miss_ready2),
    .replace_valid(replace_valid2), .replace_addr(replace_addr2), .replace(replace2),
    .read_valid(read_valid2), .read_addr(read_addr2), .read_rdata(read_rdata2),
    .line_we(line_we2), .line_addr(line_addr2), .line_wdata(line_wdata2),
    .fill_busy(fill_busy2), .fill_retries(fill_retries2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
  endtask

  task automatic chk_fail(input string name);
    n_checks++;
    $display("FAIL %s: actual=timeout/absent required=event", name);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_miss_ready"},    256'(miss_ready), 256'(1));
    chk({tag, "_replace_valid"}, 256'(replace_valid), 256'(0));
    chk({tag, "_line_we"},       256'(line_we), 256'(0));
    chk({tag, "_fill_busy"},     256'(fill_busy), 256'(0));
    chk({tag, "_fill_retries"},  256'(fill_retries), 256'(0));
    chk({tag, "_line_addr"},     256'(line_addr), 256'(0));
    chk({tag, "_replace_addr"},  256'(replace_addr), 256'(0));
    chk({tag, "_line_wdata"},    line_wdata, 256'(0));
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] l;
    for (int k = 0; k < BEATS; k++) l[k*DW +: DW] = $urandom();
    return l;
  endfunction

  function automatic plan_t mk_plan(input logic [LA_W-1:0] a, input int bursts,
                                    input int ar, input int stall, input int abort_b);
    plan_t p;
    p.addr = a; p.bursts = bursts; p.ar_delay = ar;
    p.max_stall = stall; p.abort_beat = abort_b; p.line = rand_line();
    return p;
  endfunction

  // Reference model: the committed line is the last full burst, and the
  // retry count is the number of extra bursts, saturating at 255.
  task automatic issue(input plan_t p, input bit b2b, input bit keep);
    int n;
    exp_t e;
    n = 0;
    miss_valid = 1'b1;
    miss_addr  = p.addr;
    while (!miss_ready && n < 6000) begin @(negedge clk); n++; end
    if (!miss_ready) chk_fail("miss_accept_timeout");
    else begin
      if (b2b) chk("b2b_accept_cycle", 256'(cyc), 256'(last_commit_cyc + 1));
      plan_q.push_back(p);
      issued++;
      if (p.abort_beat < 0) begin
        e.addr = p.addr;
        e.line = p.line;
        e.retries = (p.bursts - 1 > 255) ? 8'd255 : 8'(p.bursts - 1);
        exp_q.push_back(e);
      end
    end
    @(negedge clk);
    if (!keep) miss_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || plan_q.size() != 0 || fill_busy) && n < 10000) begin
      @(negedge clk); n++;
    end
    if (n >= 10000) chk_fail("idle_timeout");
  endtask

  // Read-channel model; also owns the main DUT reset.
  initial begin : read_channel
    plan_t p;
    bit aborted;
    reset = 1'b1; replace = 1'b0; read_valid = 1'b0; read_addr = '0; read_rdata = '0;
    repeat (3) @(negedge clk);
    chk_reset("por");
    reset = 1'b0;
    rst_done = 1'b1;
    forever begin
      @(negedge clk);
      if (!replace_valid) continue;
      if (plan_q.size() == 0) begin chk_fail("spurious_replace_valid"); continue; end
      p = plan_q.pop_front();
      triggers++;
      @(negedge clk);
      replace = 1'b1;
      chk("replace_valid_held_in_req", 256'(replace_valid), 256'(1));
      repeat (p.ar_delay) @(negedge clk);
      aborted = 1'b0;
      for (int b = 0; b < p.bursts; b++) begin
        for (int k = 0; k < BEATS; k++) begin
          repeat ($urandom_range(p.max_stall, 0)) begin @(negedge clk); read_valid = 1'b0; end
          @(negedge clk);
          read_valid = 1'b1;
          read_addr  = 3'(k);
          read_rdata = (b == p.bursts - 1) ? p.line[k*DW +: DW] : $urandom();
          if (b == 0 && k == p.abort_beat) begin
            reset = 1'b1;
            #1 chk_reset("abort");
            aborted = 1'b1;
          end else if (b == p.bursts - 1 && k == BEATS - 1) begin
            last_beat_cyc = cyc;
          end
          if (aborted) break;
        end
        if (aborted) break;
      end
      @(negedge clk);
      read_valid = 1'b0;
      if (aborted) begin
        reset = 1'b0;
        replace = 1'b0;
        abort_done = 1'b1;
      end else begin
        @(negedge clk);
        replace = 1'b0;
        chk("replace_valid_low_in_fill", 256'(replace_valid), 256'(0));
      end
    end
  end

  // Monitor: pops the scoreboard on every commit strobe.
  always @(negedge clk) begin
    if (rst_done && !reset) begin
      chk("miss_ready_vs_busy", 256'(miss_ready), 256'(!fill_busy));
      if (line_we) begin
        last_commit_cyc = cyc;
        if (exp_q.size() == 0) chk_fail("unexpected_line_we");
        else begin
          em = exp_q.pop_front();
          chk("line_addr", 256'(line_addr), 256'(em.addr));
          chk("line_wdata", line_wdata, em.line);
          chk("fill_retries", 256'(fill_retries), 256'(em.retries));
          chk("commit_latency", 256'(cyc), 256'(last_beat_cyc + 3));
          chk("replace_valid_in_commit", 256'(replace_valid), 256'(0));
        end
      end
    end
    if (line_we2) begin
      if (exp2_q.size() == 0) chk_fail("d2_unexpected_line_we");
      else begin
        em2 = exp2_q.pop_front();
        chk("d2_line_addr", 256'(line_addr2), 256'(em2.addr));
        chk("d2_line_wdata", line_wdata2, em2.line);
        chk("d2_fill_retries", 256'(fill_retries2), 256'(em2.retries));
        chk("d2_commit_latency", 256'(cyc), 256'(last2 + 3));
      end
    end
  end

  // Single-beat-per-line instance: one plain fill, then one re-burst fill.
  initial begin : dut2_drv
    exp_t e;
    logic [255:0] d;
    reset2 = 1'b1; miss_valid2 = 1'b0; miss_addr2 = '0; replace2 = 1'b0;
    read_valid2 = 1'b0; read_addr2 = '0; read_rdata2 = '0;
    repeat (2) @(negedge clk);
    chk("d2_reset_miss_ready", 256'(miss_ready2), 256'(1));
    chk("d2_reset_line_wdata", line_wdata2, 256'(0));
    reset2 = 1'b0;
    for (int t = 0; t < 2; t++) begin
      d = (t == 0) ? {8{32'hA5A5_A5A5}} : rand_line();
      e.addr = LA_W'($urandom());
      e.line = d;
      e.retries = 8'(t);
      @(negedge clk);
      miss_valid2 = 1'b1;
      miss_addr2  = e.addr;
      chk("d2_miss_ready", 256'(miss_ready2), 256'(1));
      exp2_q.push_back(e);
      @(negedge clk);
      miss_valid2 = 1'b0;
      @(negedge clk);
      replace2 = 1'b1;
      for (int j = 0; j <= t; j++) begin
        @(negedge clk);
        read_valid2 = 1'b1;
        read_rdata2 = (j == t) ? d : rand_line();
        last2 = cyc;
      end
      @(negedge clk);
      read_valid2 = 1'b0;
      @(negedge clk);
      replace2 = 1'b0;
      repeat (4) @(negedge clk);
    end
    chk("d2_all_commits_seen", 256'(exp2_q.size()), 256'(0));
    dut2_done = 1'b1;
  end

  initial begin : main
    plan_t p;
    int n;
    miss_valid = 1'b0;
    miss_addr  = '0;
    n = 0;
    while (!rst_done && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);

    p = mk_plan(27'h1234567, 1, 0, 0, -1);
    for (int k = 0; k < BEATS; k++) p.line[k*DW +: DW] = 32'h10 + 32'(k);
    issue(p, 1'b0, 1'b0);
    wait_idle();

    p = mk_plan(27'h1234567, 2, 0, 0, -1);
    for (int k = 0; k < BEATS; k++) p.line[k*DW +: DW] = 32'h20 + 32'(k);
    issue(p, 1'b0, 1'b0);
    wait_idle();

    p = mk_plan(LA_W'($urandom()), 1, 5, 1, -1);
    issue(p, 1'b0, 1'b0);
    wait_idle();

    for (int i = 0; i < 16; i++) begin
      p = mk_plan(LA_W'($urandom()), ($urandom_range(3, 0) == 0) ? 2 : 1,
                  int'($urandom_range(3, 0)), 2, -1);
      issue(p, i > 0, 1'b1);
    end
    miss_valid = 1'b0;
    wait_idle();

    p = mk_plan(LA_W'($urandom()), 257, 0, 0, -1);
    issue(p, 1'b0, 1'b0);
    wait_idle();

    p = mk_plan(LA_W'($urandom()), 1, 0, 0, 4);
    issue(p, 1'b0, 1'b0);
    n = 0;
    while (!abort_done && n < 200) begin @(negedge clk); n++; end
    if (!abort_done) chk_fail("abort_not_reached");
    repeat (8) @(negedge clk);

    p = mk_plan(LA_W'($urandom()), 1, 1, 1, -1);
    issue(p, 1'b0, 1'b0);
    wait_idle();
    repeat (4) @(negedge clk);

    chk("one_trigger_per_miss", 256'(triggers), 256'(issued));
    n = 0;
    while (!dut2_done && n < 1000) begin @(negedge clk); n++; end
    if (!dut2_done) chk_fail("dut2_timeout");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cache_line_fill.md
# cache_line_fill

Miss-side line-fill controller for the cache back-end. It accepts a line miss from the cache controller and drives the replace request of `read_channel_axi`. It assembles the burst beats returned by that channel into a full line buffer, then commits the whole line to the cache data/tag memories in a single write cycle. It sits directly upstream of `read_channel_axi` and consumes its `read_valid`/`read_addr`/`read_rdata` stream.

## Interface
- `FE_ADDR_W`, 32: front-end byte address width.
- `FE_DATA_W`, 32: front-end word width.
- `BE_DATA_W`, 32: back-end (AXI) word width; multiple of `FE_DATA_W`.
- `WORD_OFF_W`, 3: log2 of front-end words per line.
- `BE_BYTE_W`, $clog2(BE_DATA_W/8): derived, not overridden.
- `LINE2MEM_W`, WORD_OFF_W-$clog2(BE_DATA_W/FE_DATA_W): log2 of beats per line; may be 0.
- `LINE_W`, FE_DATA_W*2**WORD_OFF_W: line width in bits.
- `LA_W`, FE_ADDR_W-BE_BYTE_W-LINE2MEM_W: line address width.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `miss_valid`  in  1  miss request from cache controller.
- `miss_addr`  in  LA_W  line address of miss.
- `miss_ready`  out  1  miss accepted when valid&&ready.
- `replace_valid`  out  1  request to read channel.
- `replace_addr`  out  LA_W  line address to read channel.
- `replace`  in  1  read channel busy (high from its init until its return to idle).
- `read_valid`  in  1  beat valid.
- `read_addr`  in  max(LINE2MEM_W,1)  beat index within line; ignored when LINE2MEM_W==0.
- `read_rdata`  in  BE_DATA_W  beat data.
- `line_we`  out  1  one-cycle commit strobe.
- `line_addr`  out  LA_W  line address being committed.
- `line_wdata`  out  LINE_W  assembled line; beat k occupies bits [k*BE_DATA_W +: BE_DATA_W].
- `fill_busy`  out  1  high from miss acceptance through the commit cycle.
- `fill_retries`  out  8  saturating count of re-bursts in the current or last fill.

## Operation
- FSM with states IDLE, REQ, FILL, COMMIT.
- IDLE:
  - `miss_ready`=1.
  - On miss_valid: latch `miss_addr` into `line_addr`/`replace_addr`, clear beat counter and `fill_retries`, then go to REQ.
- REQ:
  - `replace_valid`=1.
  - Go to FILL the cycle after `replace` is sampled high.
  - `replace_valid` holds until then.
- FILL:
  - `replace_valid`=0.
  - On `read_valid`: write `read_rdata` into line buffer slot `read_addr` (slot 0 if LINE2MEM_W==0) and increment the beat counter.
  - If a beat arrives when the counter already equals 2**LINE2MEM_W, the read channel has re-issued the burst after a slave error. In that case, increment `fill_retries` (saturating at 255), reset the counter to 1, and overwrite the slot.
  - When `replace` is sampled low, go to COMMIT.
- COMMIT:
  - `line_we`=1 for exactly one cycle; `line_wdata` shows the buffer contents.
  - Then go to IDLE.
- Beats are captured only in FILL. A compliant AXI slave never asserts rvalid before the AR handshake.
- Line buffer slots not written during a fill keep stale data. This case cannot occur with the read channel, which only lowers `replace` after the final beat.
- `fill_busy` = state != IDLE.

## Timing
- Reset values:
  - state=IDLE, `miss_ready`=1.
  - `replace_valid`=0, `line_we`=0, `fill_busy`=0.
  - `fill_retries`=0, `line_addr`/`replace_addr`=0, line buffer=0.
- Reset mid-fill returns to IDLE immediately and abandons the line. No `line_we` is issued.
- Cycle sequence, with miss accepted at cycle 0:
  - Cycle 1: REQ, `replace_valid`=1.
  - Cycle 2: read channel in init, `replace`=1.
  - Cycle 3: FILL.
- After the last beat at cycle L, the read channel spends one cycle in end_process and returns to idle at L+2. `replace`=0 is sampled at L+2, giving COMMIT at L+3 and IDLE at L+4.
- `replace_valid` is never high in COMMIT or IDLE, so the read channel cannot re-trigger.
- `miss_valid` outside IDLE is ignored; `miss_ready`=0.

## Structure
- State encodings, `LINE2MEM_W`/`LINE_W`/`LA_W` derivations, and the `fill_retries` width belong in the shared `iob-cache.vh` header.
- No sub-module. The line buffer is a flat register array inside this block.
- The integration top instantiates this block beside `read_channel_axi`.

## Test plan
- BE=FE=32, WORD_OFF_W=3, miss_addr=0x1234567, beats 0x10..0x17 with no stalls:
  - `line_we` pulses once at L+3.
  - `line_wdata`={0x17,…,0x10}, `line_addr`=0x1234567, `fill_retries`=0.
- Same line, but beat 3 has rresp=SLVERR:
  - Full second burst 0x20..0x27.
  - Committed line is all 0x2x, `fill_retries`=1.
- LINE2MEM_W=0 (BE=256, WORD_OFF_W=3), single beat 0xA5…A5:
  - Line equals the beat; commit 3 cycles after the beat.
- arready delayed 5 cycles:
  - `replace_valid` held high throughout REQ until `replace`=1.
  - Exactly one AR handshake.
- `miss_valid` asserted continuously:
  - Second miss accepted only in the cycle after COMMIT.
- Reset asserted during beat 4 of a fill:
  - No `line_we`; all outputs at reset values.
  - A subsequent miss completes normally.
